// File: rtl/microseq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_pkg                                                  |
// | Purpose  : Shared definitions for the microseq_gen2 sequencer:           |
// |            the instruction codes JZ..TWB and the Y-source select         |
// |            encoding used by the next-address multiplexer.                |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package microseq_pkg;

  // Am2910-compatible instruction codes
  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } instr_e;

  // Next-address source select
  typedef enum logic [2:0] {
    SRC_D    = 3'd0,
    SRC_UPC  = 3'd1,
    SRC_TOP  = 3'd2,
    SRC_RE   = 3'd3,
    SRC_ZERO = 3'd4
  } ysrc_e;

endpackage
`default_nettype wire

// File: rtl/microseq_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_stack                                                |
// | Purpose  : LIFO subroutine stack for microseq_gen2 with push, pop and    |
// |            clear, defined full/empty handling and event pulses.          |
// | Ports    : clk, rst          clock, synchronous active-high reset        |
// |            push, pop, clear  operation strobes (mutually exclusive)      |
// |            push_data [AW]    value written on push                       |
// |            top [AW]          stack[sp-1], reads 0 when empty             |
// |            full, empty       sp==DEPTH / sp==0                           |
// |            overflow          pulse: push while full                      |
// |            underflow         pulse: pop while empty                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module microseq_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);
  localparam logic [IW-1:0]  IDX_MAX = IW'(DEPTH - 1);

  logic [SPW-1:0] sp;
  logic [AW-1:0]  mem [DEPTH];
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  top_idx;

  assign full  = (sp == SP_FULL);
  assign empty = (sp == '0);

  // A push into a full stack replaces the deepest-usable (top) slot
  assign wr_idx  = full ? IDX_MAX : sp[IW-1:0];
  assign top_idx = sp[IW-1:0] - IDX_ONE;
  assign top     = empty ? '0 : mem[top_idx];

  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (clear) begin
      sp <= '0;
    end else if (push) begin
      mem[wr_idx] <= push_data;
      if (!full) begin
        sp <= sp + SP_ONE;
      end
    end else if (pop) begin
      if (!empty) begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/microseq_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_gen2                                                 |
// | Purpose  : Parametrised Am2910-class microprogram sequencer: instruction |
// |            decode, next-address mux, uPC incrementer, loop counter RE    |
// |            and a LIFO subroutine stack (microseq_stack).                 |
// | Ports    : clk, rst               clock, sync active-high reset          |
// |            I[4], CCEN_BAR, CC_BAR instruction and condition inputs       |
// |            RLD_BAR, CI, D[AW]     counter force-load, carry-in, data     |
// |            Y[AW]                  next microaddress (combinational)      |
// |            PL_BAR, MAP_BAR, VECT_BAR  source-enable decodes              |
// |            FULL_BAR, EMPTY        stack status                           |
// |            STK_ERR[2]             {overflow, underflow} sticky flags     |
// | Option   : MICROSEQ_STK_ERR_EN enables the sticky stack-error flags;     |
// |            otherwise STK_ERR is tied to 2'b00.                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module microseq_gen2
  import microseq_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    I,
  input  logic          CCEN_BAR,
  input  logic          CC_BAR,
  input  logic          RLD_BAR,
  input  logic          CI,
  input  logic [AW-1:0] D,
  output logic [AW-1:0] Y,
  output logic          PL_BAR,
  output logic          MAP_BAR,
  output logic          VECT_BAR,
  output logic          FULL_BAR,
  output logic          EMPTY,
  output logic [1:0]    STK_ERR
);

  localparam logic [AW-1:0] AW_ONE = AW'(1);

  instr_e        op;
  ysrc_e         ysrc;
  logic [AW-1:0] upc;
  logic [AW-1:0] re;
  logic [AW-1:0] top;
  logic          pass;
  logic          rz;
  logic          push;
  logic          pop;
  logic          clear;
  logic          load_re;
  logic          dec_re;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  assign op   = instr_e'(I);
  assign pass = ~(CC_BAR & ~CCEN_BAR);
  assign rz   = (re == '0);

  // Decode: Y source, stack operation and counter action per instruction
  always_comb begin
    ysrc    = SRC_UPC;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    load_re = 1'b0;
    dec_re  = 1'b0;
    case (op)
      JZ: begin
        ysrc  = SRC_ZERO;
        clear = 1'b1;
      end
      CJS: if (pass) begin
        ysrc = SRC_D;
        push = 1'b1;
      end
      JMAP: ysrc = SRC_D;
      CJP:  if (pass) ysrc = SRC_D;
      PUSH: begin
        push    = 1'b1;
        load_re = pass;
      end
      JSRP: begin
        push = 1'b1;
        if (pass) ysrc = SRC_D;
        else      ysrc = SRC_RE;
      end
      CJV: if (pass) ysrc = SRC_D;
      JRP: begin
        if (pass) ysrc = SRC_D;
        else      ysrc = SRC_RE;
      end
      RFCT: begin
        if (rz) begin
          pop = 1'b1;
        end else begin
          ysrc   = SRC_TOP;
          dec_re = 1'b1;
        end
      end
      RPCT: if (!rz) begin
        ysrc   = SRC_D;
        dec_re = 1'b1;
      end
      CRTN: if (pass) begin
        ysrc = SRC_TOP;
        pop  = 1'b1;
      end
      CJPP: if (pass) begin
        ysrc = SRC_D;
        pop  = 1'b1;
      end
      LDCT: load_re = 1'b1;
      LOOP: begin
        if (pass) pop = 1'b1;
        else      ysrc = SRC_TOP;
      end
      CONT: ysrc = SRC_UPC;
      TWB: begin
        if (pass) begin
          pop = 1'b1;
        end else if (rz) begin
          ysrc = SRC_D;
          pop  = 1'b1;
        end else begin
          ysrc   = SRC_TOP;
          dec_re = 1'b1;
        end
      end
      default: ysrc = SRC_UPC;
    endcase
  end

  always_comb begin
    case (ysrc)
      SRC_D:   Y = D;
      SRC_UPC: Y = upc;
      SRC_TOP: Y = top;
      SRC_RE:  Y = re;
      default: Y = '0;
    endcase
  end

  assign PL_BAR   = ~((op != JMAP) && (op != CJV));
  assign MAP_BAR  = (op != JMAP);
  assign VECT_BAR = (op != CJV);
  assign FULL_BAR = ~full;
  assign EMPTY    = empty;

  // uPC follows the selected address; RE load has priority over decrement.
  // dec_re is only raised when RE is non-zero, so RE never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc <= '0;
      re  <= '0;
    end else begin
      upc <= Y + (CI ? AW_ONE : '0);
      if (!RLD_BAR || load_re) begin
        re <= D;
      end else if (dec_re) begin
        re <= re - AW_ONE;
      end
    end
  end

  microseq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (upc),
    .top       (top),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

`ifdef MICROSEQ_STK_ERR_EN
  logic [1:0] stk_err;

  // JZ wipes the flags in the same edge that clears the stack
  always_ff @(posedge clk) begin
    if (rst || (op == JZ)) begin
      stk_err <= 2'b00;
    end else begin
      stk_err <= stk_err | {overflow, underflow};
    end
  end

  assign STK_ERR = stk_err;
`else
  logic unused_stk_events;

  assign unused_stk_events = overflow ^ underflow;
  assign STK_ERR           = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_microseq_gen2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_microseq_gen2                                              |
// | Purpose  : Self-checking bench for microseq_gen2 (AW=12, DEPTH=5).       |
// |            Vector tables of {inputs, expected outputs}; expected values  |
// |            go through a scoreboard queue and are compared against Y,     |
// |            the decode strobes and the stack status each cycle. Status    |
// |            columns show the state left by the previous instructions.     |
// | Option   : MICROSEQ_STK_ERR_EN selects the STK_ERR expectations.         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_microseq_gen2;
  import microseq_pkg::*;

  typedef struct {
    logic [3:0]  i;
    logic        ccen_bar;
    logic        cc_bar;
    logic        rld_bar;
    logic        ci;
    logic [11:0] d;
    logic [11:0] y;
    logic        empty;
    logic        full_bar;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic [11:0] y;
    logic        pl;
    logic        map;
    logic        vect;
    logic        empty;
    logic        full_bar;
    logic [1:0]  err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  I;
  logic        CCEN_BAR;
  logic        CC_BAR;
  logic        RLD_BAR;
  logic        CI;
  logic [11:0] D;
  logic [11:0] Y;
  logic        PL_BAR;
  logic        MAP_BAR;
  logic        VECT_BAR;
  logic        FULL_BAR;
  logic        EMPTY;
  logic [1:0]  STK_ERR;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  microseq_gen2 #(
    .AW    (12),
    .DEPTH (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .I        (I),
    .CCEN_BAR (CCEN_BAR),
    .CC_BAR   (CC_BAR),
    .RLD_BAR  (RLD_BAR),
    .CI       (CI),
    .D        (D),
    .Y        (Y),
    .PL_BAR   (PL_BAR),
    .MAP_BAR  (MAP_BAR),
    .VECT_BAR (VECT_BAR),
    .FULL_BAR (FULL_BAR),
    .EMPTY    (EMPTY),
    .STK_ERR  (STK_ERR)
  );

  function automatic vec_t mk(input logic [3:0] i, input logic ccen, input logic cc,
                              input logic rld, input logic ci, input logic [11:0] d,
                              input logic [11:0] y, input logic e, input logic f,
                              input logic [1:0] err);
    vec_t v;
    v.i = i; v.ccen_bar = ccen; v.cc_bar = cc; v.rld_bar = rld; v.ci = ci; v.d = d;
    v.y = y; v.empty = e; v.full_bar = f; v.err = err;
    return v;
  endfunction

  task automatic check_out(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, nothing to compare", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (Y === e.y) passed++;
    else $display("FAIL %s.Y: got %h expected %h", name, Y, e.y);
    total++;
    if ({PL_BAR, MAP_BAR, VECT_BAR, EMPTY, FULL_BAR, STK_ERR} ===
        {e.pl, e.map, e.vect, e.empty, e.full_bar, e.err}) passed++;
    else $display("FAIL %s.status: got pl/map/vect/empty/full_bar/err=%b%b%b%b%b%b expected %b%b%b%b%b%b",
                  name, PL_BAR, MAP_BAR, VECT_BAR, EMPTY, FULL_BAR, STK_ERR,
                  e.pl, e.map, e.vect, e.empty, e.full_bar, e.err);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    I = v.i; CCEN_BAR = v.ccen_bar; CC_BAR = v.cc_bar;
    RLD_BAR = v.rld_bar; CI = v.ci; D = v.d;
    e.y        = v.y;
    e.pl       = (v.i == 4'd2) || (v.i == 4'd6);
    e.map      = (v.i != 4'd2);
    e.vect     = (v.i != 4'd6);
    e.empty    = v.empty;
    e.full_bar = v.full_bar;
`ifdef MICROSEQ_STK_ERR_EN
    e.err      = v.err;
`else
    e.err      = 2'b00;
`endif
    sb.push_back(e);
    #1;
    check_out(name);
  endtask

  initial begin
    vec_t ta[$];
    vec_t tb[$];

    //                 I     ccen cc rld ci  D        Y        E  F  err
    ta.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h000, 1, 1, 2'b00)); // reset state
    ta.push_back(mk(CJP,  1, 1, 1, 1, 12'h00F, 12'h00F, 1, 1, 2'b00)); // CCEN_BAR=1 forces pass
    ta.push_back(mk(CJS,  0, 0, 1, 1, 12'h123, 12'h123, 1, 1, 2'b00)); // push uPC=0x010
    ta.push_back(mk(CRTN, 0, 0, 1, 1, 12'h000, 12'h010, 0, 1, 2'b00)); // return to 0x010
    ta.push_back(mk(CJS,  0, 1, 1, 1, 12'h200, 12'h011, 1, 1, 2'b00)); // fail: no push
    ta.push_back(mk(CRTN, 0, 1, 1, 1, 12'h000, 12'h012, 1, 1, 2'b00)); // fail: no pop
    ta.push_back(mk(LDCT, 0, 0, 1, 1, 12'h002, 12'h013, 1, 1, 2'b00)); // RE<=2
    ta.push_back(mk(RPCT, 0, 0, 1, 1, 12'h040, 12'h040, 1, 1, 2'b00)); // RE 2->1
    ta.push_back(mk(RPCT, 0, 0, 1, 1, 12'h040, 12'h040, 1, 1, 2'b00)); // RE 1->0
    ta.push_back(mk(RPCT, 0, 0, 1, 1, 12'h040, 12'h041, 1, 1, 2'b00)); // RE==0: uPC
    ta.push_back(mk(JRP,  0, 1, 1, 0, 12'h555, 12'h000, 1, 1, 2'b00)); // RE held at 0
    ta.push_back(mk(JMAP, 0, 0, 1, 1, 12'h2AB, 12'h2AB, 1, 1, 2'b00));
    ta.push_back(mk(CJV,  0, 1, 1, 1, 12'h111, 12'h2AC, 1, 1, 2'b00));
    ta.push_back(mk(CRTN, 0, 0, 1, 1, 12'h000, 12'h000, 1, 1, 2'b00)); // pop empty: top=0
    ta.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h001, 1, 1, 2'b01)); // underflow sticky
    ta.push_back(mk(JZ,   0, 0, 1, 1, 12'h000, 12'h000, 1, 1, 2'b01));
    ta.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h001, 1, 1, 2'b00)); // JZ cleared flags
    ta.push_back(mk(PUSH, 0, 0, 1, 1, 12'h007, 12'h002, 1, 1, 2'b00)); // RE<=7
    ta.push_back(mk(PUSH, 0, 1, 1, 1, 12'h009, 12'h003, 0, 1, 2'b00)); // fail: RE kept
    ta.push_back(mk(PUSH, 0, 1, 1, 1, 12'h009, 12'h004, 0, 1, 2'b00));
    ta.push_back(mk(PUSH, 0, 1, 1, 1, 12'h009, 12'h005, 0, 1, 2'b00));
    ta.push_back(mk(PUSH, 0, 1, 1, 1, 12'h009, 12'h006, 0, 1, 2'b00)); // 5th push
    ta.push_back(mk(PUSH, 0, 1, 1, 1, 12'h009, 12'h007, 0, 0, 2'b00)); // 6th: overwrite
    ta.push_back(mk(JRP,  0, 1, 1, 1, 12'h000, 12'h007, 0, 0, 2'b10)); // RE=7, overflow
    ta.push_back(mk(LOOP, 0, 1, 1, 1, 12'h000, 12'h007, 0, 0, 2'b10)); // top overwritten
    ta.push_back(mk(RFCT, 0, 0, 0, 1, 12'h003, 12'h007, 0, 0, 2'b10)); // RLD_BAR: RE<=3
    ta.push_back(mk(JRP,  0, 1, 1, 1, 12'h000, 12'h003, 0, 0, 2'b10)); // no decrement
    ta.push_back(mk(LOOP, 0, 0, 1, 1, 12'h000, 12'h004, 0, 0, 2'b10)); // pop -> sp=4
    ta.push_back(mk(CRTN, 0, 0, 1, 1, 12'h000, 12'h005, 0, 1, 2'b10)); // stack[3]
    ta.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h006, 0, 1, 2'b10));

    tb.push_back(mk(CONT, 0, 0, 1, 0, 12'h000, 12'h000, 1, 1, 2'b00)); // after mid-run rst
    tb.push_back(mk(JRP,  0, 1, 1, 0, 12'h000, 12'h000, 1, 1, 2'b00)); // RE=0
    tb.push_back(mk(CJP,  0, 0, 1, 0, 12'hFFF, 12'hFFF, 1, 1, 2'b00));
    tb.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'hFFF, 1, 1, 2'b00)); // uPC wraps
    tb.push_back(mk(CONT, 0, 0, 1, 0, 12'h000, 12'h000, 1, 1, 2'b00));
    tb.push_back(mk(CJP,  0, 0, 1, 1, 12'h0A0, 12'h0A0, 1, 1, 2'b00));
    tb.push_back(mk(PUSH, 0, 0, 1, 1, 12'h001, 12'h0A1, 1, 1, 2'b00)); // RE<=1
    tb.push_back(mk(TWB,  0, 1, 1, 1, 12'h0AB, 12'h0A1, 0, 1, 2'b00)); // !rz: top, RE->0
    tb.push_back(mk(TWB,  0, 1, 1, 1, 12'h0AB, 12'h0AB, 0, 1, 2'b00)); // rz: D + pop
    tb.push_back(mk(JSRP, 0, 1, 1, 1, 12'h300, 12'h000, 1, 1, 2'b00)); // fail: RE, push
    tb.push_back(mk(RFCT, 0, 0, 1, 1, 12'h000, 12'h001, 0, 1, 2'b00)); // rz: uPC + pop
    tb.push_back(mk(CJPP, 0, 0, 1, 1, 12'h0CC, 12'h0CC, 1, 1, 2'b00)); // pop empty
    tb.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h0CD, 1, 1, 2'b01));
    tb.push_back(mk(TWB,  0, 0, 1, 1, 12'h000, 12'h0CE, 1, 1, 2'b01)); // pass: uPC + pop
    tb.push_back(mk(JZ,   0, 0, 1, 1, 12'h000, 12'h000, 1, 1, 2'b01));
    tb.push_back(mk(CONT, 0, 0, 1, 1, 12'h000, 12'h001, 1, 1, 2'b00));

    rst = 1'b1; I = 4'd0; CCEN_BAR = 1'b0; CC_BAR = 1'b0;
    RLD_BAR = 1'b1; CI = 1'b0; D = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < ta.size(); k++) run_vec(ta[k], $sformatf("a%0d", k));

    // Mid-run reset with a passing PUSH presented: reset must win
    @(negedge clk);
    rst = 1'b1; I = PUSH; CCEN_BAR = 1'b0; CC_BAR = 1'b0; RLD_BAR = 1'b0; D = 12'h055; CI = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; I = CONT; RLD_BAR = 1'b1; CI = 1'b0;

    for (int k = 0; k < tb.size(); k++) run_vec(tb[k], $sformatf("b%0d", k));

    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
